// File: rtl/da_pkg.sv
// Shared definitions for the DAC write controller.
//  - da_state_e : write FSM state encoding (IDLE / WRITING)
//  - CTRL_BYTE  : PCF8591-class control byte, analog-output enable
//  - MV_FULL    : highest setpoint (mV) that still maps into 0..255
//  - MV_MUL/SHR : fixed-point scale, code = (mv * MV_MUL) >> MV_SHR
package da_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WRITING = 1'b1
  } da_state_e;

  localparam logic [7:0]  CTRL_BYTE = 8'b0100_0000;
  localparam logic [11:0] MV_FULL   = 12'd3300;
  localparam logic [10:0] MV_MUL    = 11'd1271;
  localparam int          MV_SHR    = 14;

endpackage

// File: rtl/mv_to_code.sv
// Registered millivolt -> 8-bit DAC code converter.
// Ports:
//  clk   in   1   system clock
//  rst   in   1   asynchronous, active-high reset (code -> 0)
//  mv    in  12   setpoint in mV
//  code  out  8   DAC code, valid one clock after mv settles
module mv_to_code
  import da_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mv,
  output logic [7:0]  code
);

  logic [7:0] code_d;
  logic [7:0] code_q;

  // 1271/16384 ~= 255/3300; the 23-bit product truncates, never rounds.
  // Anything above full scale clamps to the top code instead of wrapping.
  function automatic logic [7:0] mv_code(input logic [11:0] mv_in);
    if (mv_in > MV_FULL) begin
      return 8'hFF;
    end
    return 8'((23'(mv_in) * 23'(MV_MUL)) >> MV_SHR);
  endfunction

  always_comb begin
    code_d = mv_code(mv);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign code = code_q;

endmodule

// File: rtl/da_ctrl.sv
// DAC write controller: issues periodic single-byte writes to the shared
// I2C master driver, either a held millivolt setpoint or a sawtooth ramp.
// Ports:
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  set_mv     in  12   setpoint in mV (0..3300 meaningful, above saturates)
//  set_valid  in   1   strobe: capture set_mv into the pending register
//  mode       in   1   0 = HOLD setpoint, 1 = RAMP sawtooth (sampled at wr_en)
//  done_flag  in   1   pulse from I2C driver: transfer complete
//  addr       out 16   {8'h00, CTRL_BYTE}
//  wr_en      out  1   single-cycle write request
//  wr_data    out  8   DAC code of the current transfer
//  busy       out  1   transfer outstanding
//  timeout    out  1   single-cycle pulse: no done_flag within TO_MAX
module da_ctrl
  import da_pkg::*;
#(
  parameter logic [20:0] CNT_MAX   = 21'd1_999_999,
  parameter logic [20:0] TO_MAX    = 21'd1_999_999,
  parameter logic [7:0]  RAMP_STEP = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] set_mv,
  input  logic        set_valid,
  input  logic        mode,
  input  logic        done_flag,
  output logic [15:0] addr,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        timeout
);

  da_state_e   state_d,     state_q;
  logic [20:0] cnt_d,       cnt_q;
  logic [11:0] pend_mv_d,   pend_mv_q;
  logic [7:0]  ramp_d,      ramp_q;
  logic        ramp_mode_d, ramp_mode_q;
  logic [15:0] addr_d,      addr_q;
  logic        wr_en_d,     wr_en_q;
  logic [7:0]  wr_data_d,   wr_data_q;
  logic        busy_d,      busy_q;
  logic        timeout_d,   timeout_q;

  logic [7:0]  hold_code;

  // The converter always tracks the pending setpoint; wr_data only samples
  // it at wr_en, so a capture mid-transfer cannot disturb the byte in flight.
  mv_to_code u_mv_to_code (
    .clk  (clk),
    .rst  (rst),
    .mv   (pend_mv_q),
    .code (hold_code)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_mv_d   = pend_mv_q;
    ramp_d      = ramp_q;
    ramp_mode_d = ramp_mode_q;
    addr_d      = {8'h00, CTRL_BYTE};
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;

    if (set_valid) begin
      pend_mv_d = set_mv;
    end

    case (state_q)
      IDLE: begin
        // done_flag is deliberately ignored here.
        if (cnt_q == CNT_MAX) begin
          cnt_d       = '0;
          wr_en_d     = 1'b1;
          busy_d      = 1'b1;
          ramp_mode_d = mode;
          state_d     = WRITING;
          if (mode) begin
            wr_data_d = ramp_q;
          end else begin
            // Seed the ramp so a later HOLD->RAMP switch continues from here.
            wr_data_d = hold_code;
            ramp_d    = hold_code;
          end
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end

      WRITING: begin
        // done_flag takes priority over an expiring timeout in the same cycle.
        if (done_flag) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
          if (ramp_mode_q) begin
            ramp_d = ramp_q + RAMP_STEP;
          end
        end else if (cnt_q == TO_MAX) begin
          // Abandoned write: ramp is left alone so the same code is retried.
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_mv_q   <= '0;
      ramp_q      <= '0;
      ramp_mode_q <= 1'b0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_mv_q   <= pend_mv_d;
      ramp_q      <= ramp_d;
      ramp_mode_q <= ramp_mode_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign addr    = addr_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_da_ctrl.sv
// Directed bench for da_ctrl with CNT_MAX=9, TO_MAX=20, RAMP_STEP=16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_da_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] set_mv = '0;
  logic        set_valid = 1'b0;
  logic        mode = 1'b0;
  logic        done_flag = 1'b0;
  logic [15:0] addr;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;

  da_ctrl #(
    .CNT_MAX   (21'd9),
    .TO_MAX    (21'd20),
    .RAMP_STEP (8'd16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set_mv    (set_mv),
    .set_valid (set_valid),
    .mode      (mode),
    .done_flag (done_flag),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Returns number of clock edges until wr_en is seen high.
  task automatic wait_wr(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!wr_en && n < budget);
    if (!wr_en) chk({tag, "_wr_bound"}, 32'(wr_en), 32'd1);
  endtask

  task automatic strobe(input logic [11:0] mv);
    set_mv    = mv;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  task automatic pulse_done();
    done_flag = 1'b1;
    step();
    done_flag = 1'b0;
  endtask

  // Finish the current transfer, then check cadence and the next code.
  task automatic next_write(input string tag, input int exp_code);
    int n;
    pulse_done();
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    wait_wr(tag, 40, n);
    chk({tag, "_gap"}, n, 10);
    chk(tag, 32'(wr_data), exp_code);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int n;

    // Reset state
    steps(2);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // First write after reset: 1650 mV -> 127 at edge 10
    rst = 1'b0;
    strobe(12'd1650);
    chk("addr_ctrl", 32'(addr), 32'h0040);
    wait_wr("first_wr", 40, n);
    chk("first_wr_cyc", n + 1, 10);
    chk("first_wr_data", 32'(wr_data), 127);
    chk("first_busy", 32'(busy), 1);
    chk("first_addr", 32'(addr), 32'h0040);
    step();
    chk("wr_en_single", 32'(wr_en), 0);
    steps(3);
    chk("busy_in_flight", 32'(busy), 1);
    chk("data_in_flight", 32'(wr_data), 127);
    next_write("hold_1650", 127);

    // Capture during WRITING must not touch the in-flight byte
    strobe(12'd500);
    chk("inflight_keep_a", 32'(wr_data), 127);
    steps(2);
    chk("inflight_keep_b", 32'(wr_data), 127);
    next_write("hold_500", 38);

    // HOLD conversion boundaries
    strobe(12'd0);
    next_write("hold_0", 0);
    strobe(12'd3300);
    next_write("hold_3300", 255);
    strobe(12'd1000);
    next_write("hold_1000", 77);
    strobe(12'd4000);
    next_write("hold_4000_sat", 255);

    // Last of several strobes wins
    strobe(12'd100);
    strobe(12'd2888);
    next_write("hold_2888", 224);

    // RAMP from last HOLD code 224, step 16, wraps at 256
    mode = 1'b1;
    next_write("ramp_224", 224);
    next_write("ramp_240", 240);
    next_write("ramp_0", 0);
    next_write("ramp_16", 16);

    // No done_flag: single timeout pulse 21 edges after wr_en
    n = 0;
    do begin
      step();
      n++;
    end while (!timeout && n < 40);
    chk("to_cyc", n, 21);
    chk("to_busy", 32'(busy), 0);
    step();
    chk("to_single", 32'(timeout), 0);
    pulse_done();  // lands in IDLE, must be ignored
    chk("idle_done_busy", 32'(busy), 0);
    wait_wr("after_to", 40, n);
    chk("after_to_gap", n + 2, 10);
    chk("retry_data", 32'(wr_data), 16);

    // done_flag coincident with cnt==TO_MAX: done wins
    steps(20);
    done_flag = 1'b1;
    step();
    done_flag = 1'b0;
    chk("tie_timeout", 32'(timeout), 0);
    chk("tie_busy", 32'(busy), 0);
    wait_wr("after_tie", 40, n);
    chk("after_tie_gap", n, 10);
    chk("after_tie_data", 32'(wr_data), 32);

    // Reset in the wr_en cycle of a transfer
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr_data", 32'(wr_data), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    step();
    rst  = 1'b0;
    mode = 1'b0;
    wait_wr("post_rst", 40, n);
    chk("post_rst_cyc", n, 10);
    chk("post_rst_data", 32'(wr_data), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d errors of %0d checks", n_err, n_chk);
    $fatal(1);
  end

endmodule
